// File: rtl/project_pkg.sv
// Shared constants and types for the matrix-multiplier datapath.
// Holds the divider state encoding and its fixed iteration latency.
package project_pkg;

    localparam int MSB         = 32;
    localparam int DIV_LATENCY = MSB;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_DONE
    } div_state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and trial-subtract.
// Pure combinational; seq_divider registers the result every clock.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    // Shifted value is kept one bit wider so a large divisor never loses the top remainder bit.
    logic [WIDTH:0] shifted;

    assign shifted = {rem_in, bit_in};
    assign q_bit   = (shifted >= {1'b0, divisor});
    assign rem_out = q_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement (truncating) division.
module seq_divider
    import project_pkg::*;
#(
    parameter int WIDTH = MSB,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] dsr_reg;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dsr_mag;
    logic [WIDTH-1:0] q_raw;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;
    logic             accept;

    assign accept = (state == DIV_IDLE) && in_valid && in_ready;
    assign q_raw  = {dvd_reg[WIDTH-2:0], step_q};

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_reg),
        .bit_in  (dvd_reg[WIDTH-1]),
        .divisor (dsr_reg),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q;
    logic neg_r;

    // Signs are captured at acceptance; the core only ever sees magnitudes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
        end
    end

    assign dvd_mag = dividend[WIDTH-1] ? ('0 - dividend) : dividend;
    assign dsr_mag = divisor[WIDTH-1]  ? ('0 - divisor)  : divisor;
    assign q_final = neg_q ? ('0 - q_raw)    : q_raw;
    assign r_final = neg_r ? ('0 - step_rem) : step_rem;
`else
    assign dvd_mag = dividend;
    assign dsr_mag = divisor;
    assign q_final = q_raw;
    assign r_final = step_rem;
`endif

    // Divide-by-zero skips CALC entirely and presents its fixed result straight away.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= DIV_IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            count       <= '0;
            rem_reg     <= '0;
            dvd_reg     <= '0;
            dsr_reg     <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        rem_reg  <= '0;
                        count    <= CNT_W'(WIDTH);
                        if (divisor == '0) begin
                            state       <= DIV_DONE;
                            out_valid   <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state       <= DIV_CALC;
                            dvd_reg     <= dvd_mag;
                            dsr_reg     <= dsr_mag;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                DIV_CALC: begin
                    rem_reg <= step_rem;
                    dvd_reg <= q_raw;
                    count   <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state     <= DIV_DONE;
                        out_valid <= 1'b1;
                        quotient  <= q_final;
                        remainder <= r_final;
                    end
                end
                DIV_DONE: begin
                    if (out_ready) begin
                        state     <= DIV_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= DIV_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
